// File: rtl/sprite_anim_ram.sv
// Multi-frame sprite store with a paced animation counter and a clear engine.
// Frames are stored back to back: linear address = frame * PIX + pixel offset.
// The memory array has no reset. Only the control and output registers do.
//
// Clear FSM states
//   state   | meaning
//   S_IDLE  | normal operation; external writes accepted
//   S_CLEAR | sweeping CLEAR_VAL over all DEPTH words; busy=1, external writes dropped
module sprite_anim_ram #(
  parameter int                 PIXEL_W         = 4,
  parameter int                 SPRITE_W        = 32,
  parameter int                 SPRITE_H        = 24,
  parameter int                 FRAMES          = 4,
  parameter int                 TICKS_PER_FRAME = 8,
  parameter logic [PIXEL_W-1:0] CLEAR_VAL       = '0,
  parameter bit                 CLEAR_ON_RESET  = 1'b1,
  localparam int PIX   = SPRITE_W * SPRITE_H,
  localparam int DEPTH = PIX * FRAMES,
  localparam int PA_W  = (PIX > 1) ? $clog2(PIX) : 1,
  localparam int FR_W  = (FRAMES > 1) ? $clog2(FRAMES) : 1
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               frame_tick,
  input  logic               anim_en,
  input  logic               anim_restart,
  input  logic               clear_req,
  input  logic               wr_en,
  input  logic [FR_W-1:0]    wr_frame,
  input  logic [PA_W-1:0]    wr_addr,
  input  logic [PIXEL_W-1:0] wr_data,
  input  logic               rd_en,
  input  logic [PA_W-1:0]    rd_addr,
  output logic [PIXEL_W-1:0] rd_data,
  output logic               rd_valid,
  output logic [FR_W-1:0]    cur_frame,
  output logic               busy
);

  // AD_W always covers DEPTH-1, so frame*PIX+offset fits for every in-range access.
  localparam int AD_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int TK_W = (TICKS_PER_FRAME > 1) ? $clog2(TICKS_PER_FRAME) : 1;

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } state_t;

  state_t             state, state_nxt;
  logic [AD_W-1:0]    clr_ptr;
  logic               clr_last;
  logic               clr_we;
  logic               init_pend;
  logic [TK_W-1:0]    tick_cnt;

  logic               wr_in_range;
  logic               wr_ok;
  logic [AD_W-1:0]    wr_lin;
  logic               rd_in_range;
  logic [AD_W-1:0]    rd_lin;

  logic               mem_we;
  logic [AD_W-1:0]    mem_wa;
  logic [PIXEL_W-1:0] mem_wd;

  logic [PIXEL_W-1:0] mem [DEPTH];

  assign clr_last = (clr_ptr == AD_W'(DEPTH - 1));

  // One-shot flag that launches the post-reset sweep on the first edge after release.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) init_pend <= CLEAR_ON_RESET;
    else          init_pend <= 1'b0;
  end

  // Clear FSM state register.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Clear FSM next state and outputs; clear_req is only looked at in S_IDLE.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    clr_we    = 1'b0;
    case (state)
      S_IDLE: begin
        if (clear_req || init_pend) state_nxt = S_CLEAR;
      end
      S_CLEAR: begin
        busy   = 1'b1;
        clr_we = 1'b1;
        if (clr_last) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Sweep pointer: walks 0..DEPTH-1 while clearing, parked at 0 otherwise.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      clr_ptr <= '0;
    end else if (state == S_CLEAR) begin
      clr_ptr <= clr_last ? '0 : clr_ptr + AD_W'(1);
    end else begin
      clr_ptr <= '0;
    end
  end

  // Write-side address decode and range qualification.
  always_comb begin
    wr_in_range = (32'(wr_frame) < 32'(FRAMES)) && (32'(wr_addr) < 32'(PIX));
    wr_lin      = AD_W'(wr_frame) * AD_W'(PIX) + AD_W'(wr_addr);
    wr_ok       = wr_en && !busy && wr_in_range;
  end

  // Single write port shared between the clear engine and the external port.
  always_comb begin
    mem_we = clr_we || wr_ok;
    mem_wa = clr_we ? clr_ptr : wr_lin;
    mem_wd = clr_we ? CLEAR_VAL : wr_data;
  end

  // Storage array, intentionally without reset so it maps onto block RAM.
  always_ff @(posedge Clk) begin
    if (mem_we) mem[mem_wa] <= mem_wd;
  end

  // Read-side address decode using the current (pre-edge) animation frame.
  always_comb begin
    rd_in_range = (32'(rd_addr) < 32'(PIX));
    rd_lin      = AD_W'(cur_frame) * AD_W'(PIX) + AD_W'(rd_addr);
  end

  // Registered read port; sees pre-write contents, so same-address access is read-first.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else if (rd_en) begin
      rd_valid <= 1'b1;
      if (rd_in_range) rd_data <= mem[rd_lin];
      else             rd_data <= CLEAR_VAL;
    end else begin
      rd_valid <= 1'b0;
    end
  end

  // Animation pacing: TICKS_PER_FRAME enabled ticks per frame step, restart wins.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      cur_frame <= '0;
      tick_cnt  <= '0;
    end else if (anim_restart) begin
      cur_frame <= '0;
      tick_cnt  <= '0;
    end else if (anim_en && frame_tick) begin
      if (tick_cnt == TK_W'(TICKS_PER_FRAME - 1)) begin
        tick_cnt  <= '0;
        cur_frame <= (cur_frame == FR_W'(FRAMES - 1)) ? '0 : cur_frame + FR_W'(1);
      end else begin
        tick_cnt  <= tick_cnt + TK_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_sprite_anim_ram.sv
// Bench for sprite_anim_ram at default parameters (768 pixels/frame, 4 frames).
module tb_sprite_anim_ram;

  logic       Clk = 1'b0;
  logic       Reset_n;
  logic       frame_tick, anim_en, anim_restart, clear_req;
  logic       wr_en;
  logic [1:0] wr_frame;
  logic [9:0] wr_addr;
  logic [3:0] wr_data;
  logic       rd_en;
  logic [9:0] rd_addr;
  logic [3:0] rd_data;
  logic       rd_valid;
  logic [1:0] cur_frame;
  logic       busy;

  sprite_anim_ram dut (
    .Clk          (Clk),
    .Reset_n      (Reset_n),
    .frame_tick   (frame_tick),
    .anim_en      (anim_en),
    .anim_restart (anim_restart),
    .clear_req    (clear_req),
    .wr_en        (wr_en),
    .wr_frame     (wr_frame),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .rd_en        (rd_en),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .cur_frame    (cur_frame),
    .busy         (busy)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic       we;
    logic [1:0] wf;
    logic [9:0] wa;
    logic [3:0] wd;
    logic       re;
    logic [9:0] ra;
    logic [3:0] exp_rd;
  } vec_t;

  vec_t       vecs[11];
  logic [3:0] exp_q[$];
  logic [3:0] held;
  bit         sb_on;
  int         checks;
  int         errors;
  int         mdl_tick;
  int         mdl_frame;
  int         n;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock; compares read-port outputs against the scoreboard when enabled.
  task automatic cycle();
    logic re_q;
    logic [3:0] e;
    re_q = rd_en;
    @(posedge Clk);
    #1;
    if (sb_on) begin
      if (re_q) begin
        chk("rd_valid_high", rd_valid, 1);
        if (exp_q.size() == 0) begin
          chk("scoreboard_empty", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("rd_data", rd_data, e);
          held = e;
        end
      end else begin
        chk("rd_valid_low", rd_valid, 0);
        chk("rd_data_hold", rd_data, held);
      end
    end
  endtask

  task automatic rd(input logic [9:0] a, input logic [3:0] e);
    rd_en   = 1'b1;
    rd_addr = a;
    exp_q.push_back(e);
    cycle();
    rd_en = 1'b0;
  endtask

  task automatic pulse(input logic restart);
    frame_tick   = 1'b1;
    anim_restart = restart;
    if (restart) begin
      mdl_frame = 0;
      mdl_tick  = 0;
    end else if (anim_en) begin
      if (mdl_tick == 7) begin
        mdl_tick  = 0;
        mdl_frame = (mdl_frame == 3) ? 0 : mdl_frame + 1;
      end else begin
        mdl_tick++;
      end
    end
    cycle();
    frame_tick   = 1'b0;
    anim_restart = 1'b0;
    chk("cur_frame", cur_frame, mdl_frame);
  endtask

  // Counts consecutive busy cycles following a sweep start.
  task automatic count_busy(output int cnt);
    cnt = busy ? 1 : 0;
    while (busy && cnt < 4000) begin
      cycle();
      if (busy) cnt++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    // {we, wf, wa, wd, re, ra, expected rd_data}
    vecs[0]  = '{1'b1, 2'd0, 10'd7,    4'h3, 1'b0, 10'd0,    4'h0};
    vecs[1]  = '{1'b1, 2'd0, 10'd7,    4'h9, 1'b1, 10'd7,    4'h3};
    vecs[2]  = '{1'b0, 2'd0, 10'd0,    4'h0, 1'b1, 10'd7,    4'h9};
    vecs[3]  = '{1'b1, 2'd0, 10'd768,  4'hE, 1'b0, 10'd0,    4'h0};
    vecs[4]  = '{1'b1, 2'd0, 10'd1023, 4'h5, 1'b1, 10'd768,  4'h0};
    vecs[5]  = '{1'b1, 2'd2, 10'd5,    4'hA, 1'b1, 10'd0,    4'h0};
    vecs[6]  = '{1'b1, 2'd3, 10'd767,  4'h7, 1'b1, 10'd767,  4'h0};
    vecs[7]  = '{1'b1, 2'd0, 10'd0,    4'hC, 1'b1, 10'd3,    4'h0};
    vecs[8]  = '{1'b0, 2'd0, 10'd0,    4'h0, 1'b1, 10'd0,    4'hC};
    vecs[9]  = '{1'b0, 2'd0, 10'd0,    4'h0, 1'b1, 10'd1023, 4'h0};
    vecs[10] = '{1'b0, 2'd0, 10'd0,    4'h0, 1'b0, 10'd0,    4'h0};

    checks = 0; errors = 0; sb_on = 1'b0; held = 4'h0;
    mdl_tick = 0; mdl_frame = 0;
    Reset_n = 1'b0;
    frame_tick = 0; anim_en = 0; anim_restart = 0; clear_req = 0;
    wr_en = 0; wr_frame = 0; wr_addr = 0; wr_data = 0; rd_en = 0; rd_addr = 0;

    repeat (3) @(posedge Clk);
    #1;
    chk("reset_rd_data", rd_data, 0);
    chk("reset_rd_valid", rd_valid, 0);
    chk("reset_cur_frame", cur_frame, 0);
    chk("reset_busy", busy, 0);

    // Automatic sweep after release; a clear_req and a write inside it must be ignored.
    Reset_n = 1'b1;
    cycle();
    chk("sweep_start_busy", busy, 1);
    n = busy ? 1 : 0;
    while (busy && n < 4000) begin
      if (n == 100) clear_req = 1'b1;
      if (n == 200) begin
        wr_en = 1'b1; wr_frame = 2'd0; wr_addr = 10'd3; wr_data = 4'hF;
      end
      cycle();
      clear_req = 1'b0;
      wr_en     = 1'b0;
      if (busy) n++;
    end
    chk("sweep_len", n, 3072);
    repeat (3) cycle();
    chk("idle_after_sweep", busy, 0);

    // Table-driven writes/reads at frame 0.
    sb_on = 1'b1;
    for (int i = 0; i < 11; i++) begin
      wr_en = vecs[i].we; wr_frame = vecs[i].wf; wr_addr = vecs[i].wa; wr_data = vecs[i].wd;
      rd_en = vecs[i].re; rd_addr = vecs[i].ra;
      if (vecs[i].re) exp_q.push_back(vecs[i].exp_rd);
      cycle();
    end
    wr_en = 1'b0; rd_en = 1'b0;

    // Animation stepping, with reads of each frame along the way.
    anim_en = 1'b1;
    repeat (8) pulse(1'b0);
    rd(10'd0, 4'h0);
    rd(10'd255, 4'h0);
    cycle();
    repeat (8) pulse(1'b0);
    rd(10'd5, 4'hA);
    cycle();
    repeat (8) pulse(1'b0);
    rd(10'd767, 4'h7);
    repeat (8) pulse(1'b0);
    chk("wrap_frame", cur_frame, 0);
    anim_en = 1'b0;
    repeat (8) pulse(1'b0);
    anim_en = 1'b1;
    repeat (7) pulse(1'b0);
    pulse(1'b1);
    repeat (7) pulse(1'b0);
    pulse(1'b0);
    chk("after_restart_frame", cur_frame, 1);

    // Reads are served mid-sweep; reset then aborts the sweep.
    anim_en = 1'b0;
    wr_en = 1'b1; wr_frame = 2'd1; wr_addr = 10'd2; wr_data = 4'hB;
    cycle();
    wr_en = 1'b0;
    rd(10'd2, 4'hB);
    clear_req = 1'b1;
    cycle();
    clear_req = 1'b0;
    chk("req_busy", busy, 1);
    rd(10'd2, 4'hB);
    repeat (998) cycle();
    chk("mid_sweep_busy", busy, 1);
    sb_on = 1'b0;
    Reset_n = 1'b0;
    #1;
    chk("abort_rd_data", rd_data, 0);
    chk("abort_rd_valid", rd_valid, 0);
    chk("abort_cur_frame", cur_frame, 0);
    chk("abort_busy", busy, 0);
    @(posedge Clk);
    #1;
    Reset_n = 1'b1;
    cycle();
    count_busy(n);
    chk("resweep_len", n, 3072);
    exp_q.delete();
    held = 4'h0;
    sb_on = 1'b1;
    rd(10'd7, 4'h0);
    rd(10'd0, 4'h0);
    cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
